// File: rtl/link_peer.sv
// Serial link peer: sends and receives one byte MSB first over an SCK/data pair,
// either driving SCK itself (master) or following an external SCK (slave).
module link_peer (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_abort,
  input  logic        master,
  input  logic [7:0]  div,
  input  logic [11:0] timeout,
  input  logic        sck_in,
  output logic        sck_out,
  output logic        sck_oe,
  input  logic        sin,
  output logic        sout
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DIV_W  = 8;
  localparam int unsigned TO_W   = 12;
  localparam int unsigned BIT_W  = 3;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] XFER_M = 2'd1;
  localparam logic [1:0] XFER_S = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [BIT_W-1:0]  bcnt_q, bcnt_d;
  logic [DIV_W-1:0]  hcnt_q, hcnt_d;
  logic [TO_W-1:0]   tcnt_q, tcnt_d;
  logic              cap_q, cap_d;
  logic              rx_valid_q, rx_valid_d;
  logic              rx_abort_q, rx_abort_d;
  logic              tx_ready_q, tx_ready_d;
  logic              sck_out_q, sck_out_d;
  logic              sck_oe_q, sck_oe_d;
  logic              sout_q, sout_d;

  logic sck_meta_q, sck_sync_q, sck_prev_q;
  logic sin_meta_q, sin_sync_q;

  logic [DIV_W-1:0] div_eff;
  logic             hs, tick_m, edge_s, rise, fall, last, to_hit;

  // Two-flop synchronizers; the third sck flop gives the edge reference
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      sck_meta_q <= 1'b1;
      sck_sync_q <= 1'b1;
      sck_prev_q <= 1'b1;
      sin_meta_q <= 1'b1;
      sin_sync_q <= 1'b1;
    end else begin
      sck_meta_q <= sck_in;
      sck_sync_q <= sck_meta_q;
      sck_prev_q <= sck_sync_q;
      sin_meta_q <= sin;
      sin_sync_q <= sin_meta_q;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q    <= IDLE;
      sr_q       <= 8'hFF;
      rx_data_q  <= 8'h00;
      bcnt_q     <= '0;
      hcnt_q     <= '0;
      tcnt_q     <= '0;
      cap_q      <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_abort_q <= 1'b0;
      tx_ready_q <= 1'b1;
      sck_out_q  <= 1'b1;
      sck_oe_q   <= 1'b0;
      sout_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      rx_data_q  <= rx_data_d;
      bcnt_q     <= bcnt_d;
      hcnt_q     <= hcnt_d;
      tcnt_q     <= tcnt_d;
      cap_q      <= cap_d;
      rx_valid_q <= rx_valid_d;
      rx_abort_q <= rx_abort_d;
      tx_ready_q <= tx_ready_d;
      sck_out_q  <= sck_out_d;
      sck_oe_q   <= sck_oe_d;
      sout_q     <= sout_d;
    end
  end

  // Link clock events: generated half-period ticks in master, synchronized edges in slave
  always_comb begin
    div_eff = (div == 8'd0) ? 8'd1 : div;
    hs      = (state_q == IDLE) && tx_ready_q && tx_valid;
    tick_m  = (state_q == XFER_M) && (hcnt_q == div_eff - 8'd1);
    edge_s  = (state_q == XFER_S) && (sck_sync_q != sck_prev_q);
    rise    = 1'b0;
    fall    = 1'b0;
    if (state_q == XFER_M) begin
      rise = tick_m && !sck_out_q;
      fall = tick_m && sck_out_q;
    end else if (state_q == XFER_S) begin
      rise = edge_s && sck_sync_q;
      fall = edge_s && !sck_sync_q;
    end
    last   = rise && (bcnt_q == 3'd7);
    to_hit = (state_q == XFER_S) && (timeout != 12'd0) && (tcnt_q == timeout);
  end

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    rx_data_d  = rx_data_q;
    bcnt_d     = bcnt_q;
    hcnt_d     = hcnt_q;
    tcnt_d     = tcnt_q;
    cap_d      = cap_q;
    rx_valid_d = 1'b0;
    rx_abort_d = 1'b0;
    sck_out_d  = sck_out_q;
    sck_oe_d   = sck_oe_q;

    case (state_q)
      IDLE: begin
        if (hs) begin
          sr_d   = tx_data;
          bcnt_d = '0;
          hcnt_d = '0;
          tcnt_d = '0;
          if (master) begin
            state_d  = XFER_M;
            sck_oe_d = 1'b1;
          end else begin
            state_d = XFER_S;
          end
        end
      end
      XFER_M, XFER_S: begin
        if (state_q == XFER_M) begin
          if (tick_m) begin
            hcnt_d    = '0;
            sck_out_d = !sck_out_q;
          end else begin
            hcnt_d = hcnt_q + 8'd1;
          end
        end else begin
          tcnt_d = edge_s ? '0 : tcnt_q + 12'd1;
        end
        // The first falling edge only opens the bit cell; MSB is already on sout
        if (fall && (bcnt_q != 3'd0)) begin
          sr_d = {sr_q[6:0], cap_q};
        end
        if (rise) begin
          cap_d  = sin_sync_q;
          bcnt_d = bcnt_q + 3'd1;
        end
        if (last) begin
          rx_data_d  = {sr_q[6:0], sin_sync_q};
          rx_valid_d = 1'b1;
          state_d    = IDLE;
          sck_out_d  = 1'b1;
          sck_oe_d   = 1'b0;
          hcnt_d     = '0;
          tcnt_d     = '0;
          bcnt_d     = '0;
        end else if (to_hit) begin
          rx_abort_d = 1'b1;
          state_d    = IDLE;
          tcnt_d     = '0;
          bcnt_d     = '0;
        end
      end
      default: begin
        state_d   = IDLE;
        sck_out_d = 1'b1;
        sck_oe_d  = 1'b0;
      end
    endcase

    tx_ready_d = (state_d == IDLE) && !rx_valid_d;
    sout_d     = (state_d == IDLE) ? 1'b1 : sr_d[7];
  end

  assign tx_ready = tx_ready_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_abort = rx_abort_q;
  assign sck_out  = sck_out_q;
  assign sck_oe   = sck_oe_q;
  assign sout     = sout_q;

endmodule

// File: doc/link_peer.md
LINK_PEER -- requirements
Module: link_peer

Interface
REQ-001 SHALL have clk, input, 1: single system clock; all state changes on its rising edge.
REQ-002 SHALL have n_reset, input, 1: reset, asynchronous and active-low.
REQ-003 SHALL have tx_data, input, 8: byte to send on the link, MSB first.
REQ-004 SHALL have tx_valid, input, 1: tx_data offered; accepted when tx_valid and tx_ready are both high on a clock edge.
REQ-005 SHALL have tx_ready, output, 1: high only in IDLE.
REQ-006 SHALL have rx_data, output, 8: last byte received; holds its value until the next completion.
REQ-007 SHALL have rx_valid, output, 1: one-cycle completion pulse.
REQ-008 SHALL have rx_abort, output, 1: one-cycle pulse when a slave-mode timeout fires.
REQ-009 SHALL have master, input, 1: 1 = peer drives SCK, 0 = peer follows external SCK.
REQ-010 SHALL have div, input, 8: SCK half-period in clk cycles; 0 is treated as 1.
REQ-011 SHALL have timeout, input, 12: slave-mode inter-edge limit in clk cycles; 0 disables the timeout.
REQ-012 SHALL have sck_in, input, 1: external link clock, asynchronous.
REQ-013 SHALL have sck_out, output, 1: driven link clock, idle high.
REQ-014 SHALL have sck_oe, output, 1: sck_out enable; high only during a master-mode transfer.
REQ-015 SHALL have sin, input, 1: data from the console's serial output, asynchronous.
REQ-016 SHALL have sout, output, 1: data to the console's serial input, idle high.

Function
REQ-017 SHALL synchronize sck_in and sin through two flops each.
- Edges are detected on the synchronized sck_in.
- Edge-detect latency is 3 clk cycles.
REQ-018 SHALL implement the states IDLE, XFER_M and XFER_S.
- Handshake in IDLE goes to XFER_M if master=1, otherwise XFER_S.
- master is sampled at the handshake only.
REQ-019 SHALL, on handshake, load a shift register sr with tx_data, clear the 3-bit bit counter, and drive sout = sr[7] from the next cycle.
REQ-020 SHALL, on each SCK rising edge, sample synchronized sin into a capture bit.
REQ-021 SHALL, on each SCK falling edge, perform sr <= {sr[6:0], capture}, with sout following sr[7].
REQ-022 SHALL, on the 8th rising edge, complete the transfer:
- rx_data <= {sr[6:0], sampled sin};
- rx_valid pulses for one cycle;
- return to IDLE;
- sout returns to 1.
REQ-023 SHALL, in XFER_M, generate SCK from a half-period counter:
- sck_out falls div cycles after entry, then toggles every div cycles;
- 8 low/high periods, ending high;
- sck_oe drops in the completion cycle.
REQ-024 SHALL, in XFER_S, reload an inter-edge counter on each detected sck edge.
- If timeout is non-zero and the counter reaches timeout, pulse rx_abort, leave rx_data unchanged, and return to IDLE.
REQ-025 SHALL ignore sck_in edges while in IDLE and in XFER_M; sout stays 1 in IDLE, so the console receives 0xFF.
REQ-026 SHALL hold tx_ready low in the completion cycle; a tx_valid in that cycle is not accepted, and a handshake first becomes possible the following cycle.
REQ-027 SHALL give completion priority over a timeout reached in the same cycle.

Reset
REQ-028 SHALL, while n_reset=0, force:
- state=IDLE;
- sr=0xFF;
- rx_data=0x00;
- rx_valid=0, rx_abort=0;
- tx_ready=1 after release;
- sck_out=1, sck_oe=0, sout=1;
- all counters 0.
REQ-029 SHALL abandon any transfer on reset assertion mid-operation, with no rx_valid or rx_abort pulse.

Verification
REQ-030 SHALL be verified in master mode: master=1, div=4, tx 0xA5, sin looped to sout -> 8 SCK periods of 8 cycles each, rx_data=0xA5, one rx_valid pulse, sck_oe low afterward.
REQ-031 SHALL be verified in slave mode: master=0, tx 0x3C, bench drives 8 SCK periods of 40 cycles with sin bits of 0xC3 -> sout carries 0x3C MSB first, rx_data=0xC3.
REQ-032 SHALL be verified for timeout: slave, timeout=100, 3 SCK periods then SCK held high -> rx_abort pulses about 100 cycles after the last edge, rx_data unchanged, tx_ready=1.
REQ-033 SHALL be verified for idle edges: no byte loaded, 8 external SCK periods -> sout constant 1, no rx_valid.
REQ-034 SHALL be verified for reset mid-transfer: n_reset low after 4 bits in master mode -> sck_out=1, sck_oe=0, sout=1 immediately, no pulses, next transfer correct.
REQ-035 SHALL be verified for back-to-back transfers: tx_valid held high across completion -> second handshake exactly one cycle after rx_valid; div=0 behaves as div=1.
